// File: rtl/ipg_pkg.sv
// Shared encodings for the IPG transmit path: sync headers, block type codes,
// message classes and the lock states of the message arbiter.
package ipg_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BLOCK_TYPE_CTRL        = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_READ        = 8'h1a;
    localparam logic [7:0] BLOCK_TYPE_WRITE       = 8'h1b;
    localparam logic [7:0] BLOCK_TYPE_RRESP       = 8'h1c;
    localparam logic [7:0] BLOCK_TYPE_READ_FIRST  = 8'h2a;
    localparam logic [7:0] BLOCK_TYPE_WRITE_FIRST = 8'h2c;
    localparam logic [7:0] BLOCK_TYPE_RRESP_FIRST = 8'h2b;
    localparam logic [7:0] BLOCK_TYPE_READ_LAST   = 8'h0a;
    localparam logic [7:0] BLOCK_TYPE_WRITE_LAST  = 8'h0c;
    localparam logic [7:0] BLOCK_TYPE_RRESP_LAST  = 8'h0b;

    // Values double as bit positions in the valid/last/grant vectors.
    typedef enum logic [1:0] {
        RREQ  = 2'd0,
        WREQ  = 2'd1,
        RRESP = 2'd2
    } msg_class_e;

    typedef enum logic [1:0] {
        NONE,
        LOCK_RREQ,
        LOCK_WREQ,
        LOCK_RRESP
    } lock_state_e;

    // Round-robin successor: rreq -> wreq -> rresp -> rreq.
    function automatic msg_class_e next_class(input msg_class_e c);
        case (c)
            RREQ:    return WREQ;
            WREQ:    return RRESP;
            default: return RREQ;
        endcase
    endfunction

    function automatic lock_state_e lock_of(input msg_class_e c);
        case (c)
            RREQ:    return LOCK_RREQ;
            WREQ:    return LOCK_WREQ;
            default: return LOCK_RRESP;
        endcase
    endfunction

    // Block type for a beat: single and middle beats share one code,
    // first-only and last-only beats have their own.
    function automatic logic [7:0] block_type(input msg_class_e c,
                                              input logic first,
                                              input logic last);
        logic [7:0] t;
        case (c)
            RREQ:    t = BLOCK_TYPE_READ;
            WREQ:    t = BLOCK_TYPE_WRITE;
            default: t = BLOCK_TYPE_RRESP;
        endcase
        if (first && !last) begin
            case (c)
                RREQ:    t = BLOCK_TYPE_READ_FIRST;
                WREQ:    t = BLOCK_TYPE_WRITE_FIRST;
                default: t = BLOCK_TYPE_RRESP_FIRST;
            endcase
        end else if (!first && last) begin
            case (c)
                RREQ:    t = BLOCK_TYPE_READ_LAST;
                WREQ:    t = BLOCK_TYPE_WRITE_LAST;
                default: t = BLOCK_TYPE_RRESP_LAST;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/ipg_tx_if.sv
// Block stream and message channel bundle of the IPG transmitter.
// slave = the transmitter, master = encoder/message sources/PHY side.
interface ipg_tx_if;
    logic [63:0] encoded_tx_data;
    logic [1:0]  encoded_tx_hdr;
    logic [63:0] out_encoded_tx_data;
    logic [1:0]  out_encoded_tx_hdr;

    logic [55:0] rreq_data;
    logic        rreq_last;
    logic        rreq_valid;
    logic        rreq_ready;

    logic [55:0] wreq_data;
    logic        wreq_last;
    logic        wreq_valid;
    logic        wreq_ready;

    logic [55:0] rresp_data;
    logic        rresp_last;
    logic        rresp_valid;
    logic        rresp_ready;

    logic        tx_busy;

    modport slave (
        input  encoded_tx_data, encoded_tx_hdr,
        input  rreq_data, rreq_last, rreq_valid,
        input  wreq_data, wreq_last, wreq_valid,
        input  rresp_data, rresp_last, rresp_valid,
        output out_encoded_tx_data, out_encoded_tx_hdr,
        output rreq_ready, wreq_ready, rresp_ready,
        output tx_busy
    );

    modport master (
        output encoded_tx_data, encoded_tx_hdr,
        output rreq_data, rreq_last, rreq_valid,
        output wreq_data, wreq_last, wreq_valid,
        output rresp_data, rresp_last, rresp_valid,
        input  out_encoded_tx_data, out_encoded_tx_hdr,
        input  rreq_ready, wreq_ready, rresp_ready,
        input  tx_busy
    );
endinterface

// File: rtl/ipg_tx_arb.sv
// Message arbiter: lock FSM, round-robin pointer and one-hot grant.
// A grant is only ever issued to a valid class in a free slot, so a grant
// bit is itself the transfer strobe for that class.
module ipg_tx_arb
    import ipg_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slot,
    input  logic [2:0] valid,
    input  logic [2:0] last,
    output logic [2:0] grant,
    output logic       tx_busy
);

    lock_state_e state;
    msg_class_e  ptr;
    msg_class_e  gcls;
    msg_class_e  cand;

    // Grant generation: lock owner only, otherwise RR search or fixed priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        grant = '0;
        cand  = ptr;
        if (slot) begin
            case (state)
                NONE: begin
                    if (RR_EN) begin
                        for (int k = 0; k < 3; k++) begin
                            if (grant == '0 && valid[cand]) grant[cand] = 1'b1;
                            cand = next_class(cand);
                        end
                    end else if (valid[RRESP]) begin
                        grant[RRESP] = 1'b1;
                    end else if (valid[WREQ]) begin
                        grant[WREQ] = 1'b1;
                    end else if (valid[RREQ]) begin
                        grant[RREQ] = 1'b1;
                    end
                end
                LOCK_RREQ:  grant[RREQ]  = valid[RREQ];
                LOCK_WREQ:  grant[WREQ]  = valid[WREQ];
                LOCK_RRESP: grant[RRESP] = valid[RRESP];
                default:    grant = '0;
            endcase
        end
    end

    // One-hot grant back to a class index.
    always_comb begin
        gcls = RREQ;
        if (grant[WREQ])  gcls = WREQ;
        if (grant[RRESP]) gcls = RRESP;
    end

    // Lock FSM: enter the lock on a non-last beat, release on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NONE;
            ptr     <= RREQ;
            tx_busy <= 1'b0;
        end else if (grant != '0) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (last[gcls]) begin
                state   <= NONE;
                tx_busy <= 1'b0;
                if (RR_EN) ptr <= next_class(gcls);
            end else begin
                state   <= lock_of(gcls);
                tx_busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ipg_tx.sv
// IPG transmitter: replaces idle control blocks in the 64b/66b TX stream with
// 56-bit memory messages (read request, write request, read response).
// Every block, passed or inserted, leaves exactly one cycle after it enters.
// Optional build macro IPG_TX_STATS_EN adds saturating insert/stall counters.
module ipg_tx
    import ipg_pkg::*;
#(
    parameter bit         RR_EN   = 1'b1,
    parameter logic [7:0] BT_IDLE = 8'h1e
) (
    input  logic        clk,
    input  logic        rst,
    ipg_tx_if.slave     bus
`ifdef IPG_TX_STATS_EN
    ,
    output logic [31:0] stat_ins_cnt,
    output logic [31:0] stat_stall_cnt
`endif
);

    logic        slot;
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [2:0]  grant;
    logic [2:0]  first_q;
    msg_class_e  ins_cls;
    logic [55:0] ins_payload;

    assign valid = {bus.rresp_valid, bus.wreq_valid, bus.rreq_valid};
    assign last  = {bus.rresp_last,  bus.wreq_last,  bus.rreq_last};

    // A free slot is a pure idle control block; anything else is preserved.
    always_comb begin
        slot = (bus.encoded_tx_hdr == SYNC_CTRL) &&
               (bus.encoded_tx_data[7:0] == BT_IDLE) &&
               (bus.encoded_tx_data[63:8] == '0);
    end

    ipg_tx_arb #(.RR_EN(RR_EN)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .slot    (slot),
        .valid   (valid),
        .last    (last),
        .grant   (grant),
        .tx_busy (bus.tx_busy)
    );

    assign bus.rreq_ready  = grant[RREQ];
    assign bus.wreq_ready  = grant[WREQ];
    assign bus.rresp_ready = grant[RRESP];

    // Select the payload of the granted class.
    always_comb begin
        ins_cls     = RREQ;
        ins_payload = bus.rreq_data;
        if (grant[WREQ]) begin
            ins_cls     = WREQ;
            ins_payload = bus.wreq_data;
        end
        if (grant[RRESP]) begin
            ins_cls     = RRESP;
            ins_payload = bus.rresp_data;
        end
    end

    // Output register: inserted message block or the incoming block unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_encoded_tx_hdr  <= SYNC_CTRL;
            bus.out_encoded_tx_data <= {56'd0, BLOCK_TYPE_CTRL};
        end else if (grant != '0) begin
            bus.out_encoded_tx_hdr  <= SYNC_CTRL;
            bus.out_encoded_tx_data <= {ins_payload,
                                        block_type(ins_cls, first_q[ins_cls], last[ins_cls])};
        end else begin
            bus.out_encoded_tx_hdr  <= bus.encoded_tx_hdr;
            bus.out_encoded_tx_data <= bus.encoded_tx_data;
        end
    end

    // Per-class first flag: the beat after a last beat starts a new message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (grant[i]) first_q[i] <= last[i];
            end
        end
    end

`ifdef IPG_TX_STATS_EN
    // Saturating counters of inserted blocks and stalled-valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ins_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (grant != '0 && stat_ins_cnt != '1)
                stat_ins_cnt <= stat_ins_cnt + 32'd1;
            if (valid != '0 && grant == '0 && stat_stall_cnt != '1)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ipg_tx.sv
// Testbench for ipg_tx: directed stimulus drives blocks and message beats on
// the falling edge and queues the expected output block; a monitor pops and
// compares the registered output after every rising edge.
module tb_ipg_tx;

    localparam logic [65:0] IDLE_BLK = {2'b01, 64'h1e};

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        string       name;
        logic [65:0] blk;
    } exp_t;

    exp_t exp_q[$];

    ipg_tx_if bus ();

`ifdef IPG_TX_STATS_EN
    logic [31:0] stat_ins_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    ipg_tx #(.RR_EN(1'b1), .BT_IDLE(8'h1e)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef IPG_TX_STATS_EN
        ,
        .stat_ins_cnt   (stat_ins_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one output block per cycle, compared against the scoreboard.
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {bus.out_encoded_tx_hdr, bus.out_encoded_tx_data}, e.blk);
        end
    end

    task automatic set_msg(input int cls, input logic v, input logic l, input logic [55:0] d);
        case (cls)
            0: begin bus.rreq_valid  = v; bus.rreq_last  = l; bus.rreq_data  = d; end
            1: begin bus.wreq_valid  = v; bus.wreq_last  = l; bus.wreq_data  = d; end
            default: begin bus.rresp_valid = v; bus.rresp_last = l; bus.rresp_data = d; end
        endcase
    endtask

    // Called on a falling edge: present one block, check readies, queue output.
    task automatic drive(input string name, input logic [65:0] blk,
                         input logic [2:0] exp_rdy, input logic [65:0] exp_out);
        exp_t e;
        bus.encoded_tx_hdr  = blk[65:64];
        bus.encoded_tx_data = blk[63:0];
        e.name = name;
        e.blk  = exp_out;
        exp_q.push_back(e);
        #1;
        check({name, "_rdy"}, {63'd0, bus.rresp_ready, bus.wreq_ready, bus.rreq_ready},
              {63'd0, exp_rdy});
        @(negedge clk);
    endtask

    task automatic check_busy(input string name, input logic exp);
        check(name, {65'd0, bus.tx_busy}, {65'd0, exp});
    endtask

    localparam logic [55:0] P2  = 56'h00112233445566;
    localparam logic [55:0] PA  = 56'h0a0a0a0a0a0a0a;
    localparam logic [55:0] PB  = 56'h0b0b0b0b0b0b0b;
    localparam logic [55:0] PC  = 56'h0c0c0c0c0c0c0c;
    localparam logic [55:0] PR  = 56'haa000000000001;
    localparam logic [55:0] PW  = 56'hbb000000000002;
    localparam logic [55:0] PS  = 56'hcc000000000003;
    localparam logic [55:0] P51 = 56'h51515151515151;
    localparam logic [55:0] P52 = 56'h52525252525252;
    localparam logic [55:0] P61 = 56'h61616161616161;
    localparam logic [55:0] P62 = 56'h62626262626262;

    localparam logic [65:0] DATA_BLK = {2'b10, 64'hdeadbeefcafef00d};
    localparam logic [65:0] TERM_BLK = {2'b01, 64'h0000000000000087};
    localparam logic [65:0] OS_BLK   = {2'b01, 64'h000000000000004b};
    localparam logic [65:0] DIRTY_ID = {2'b01, 64'h000000000000011e};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.encoded_tx_hdr  = 2'b01;
        bus.encoded_tx_data = 64'h1e;
        for (int c = 0; c < 3; c++) set_msg(c, 1'b0, 1'b0, 56'd0);

        // Reset state.
        #12;
        check("rst_out", {bus.out_encoded_tx_hdr, bus.out_encoded_tx_data}, IDLE_BLK);
        check_busy("rst_busy", 1'b0);
        check("rst_rdy", {63'd0, bus.rresp_ready, bus.wreq_ready, bus.rreq_ready}, 66'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: pass-through with no messages pending.
        drive("t1_idle0", IDLE_BLK, 3'b000, IDLE_BLK);
        drive("t1_idle1", IDLE_BLK, 3'b000, IDLE_BLK);
        drive("t1_data",  DATA_BLK, 3'b000, DATA_BLK);
        drive("t1_term",  TERM_BLK, 3'b000, TERM_BLK);

        // 2: single-beat read request stalls over non-slots, then inserts.
        set_msg(0, 1'b1, 1'b1, P2);
        drive("t2_data",  DATA_BLK, 3'b000, DATA_BLK);
        drive("t2_os",    OS_BLK,   3'b000, OS_BLK);
        drive("t2_dirty", DIRTY_ID, 3'b000, DIRTY_ID);
        drive("t2_ins",   IDLE_BLK, 3'b001, {2'b01, 64'h001122334455661a});
        set_msg(0, 1'b0, 1'b0, 56'd0);
        check_busy("t2_busy", 1'b0);

        // 3: three-beat write with a data block between beats 1 and 2.
        set_msg(1, 1'b1, 1'b0, PA);
        drive("t3_a", IDLE_BLK, 3'b010, {2'b01, PA, 8'h2c});
        check_busy("t3_busy_a", 1'b1);
        set_msg(1, 1'b1, 1'b0, PB);
        drive("t3_data", DATA_BLK, 3'b000, DATA_BLK);
        check_busy("t3_busy_d", 1'b1);
        drive("t3_b", IDLE_BLK, 3'b010, {2'b01, PB, 8'h1b});
        check_busy("t3_busy_b", 1'b1);
        set_msg(1, 1'b1, 1'b1, PC);
        drive("t3_c", IDLE_BLK, 3'b010, {2'b01, PC, 8'h0c});
        set_msg(1, 1'b0, 1'b0, 56'd0);
        check_busy("t3_busy_c", 1'b0);

        // 4: round robin; pointer sits at rresp after the write completed.
        set_msg(0, 1'b1, 1'b1, PR);
        set_msg(1, 1'b1, 1'b1, PW);
        set_msg(2, 1'b1, 1'b1, PS);
        for (int r = 0; r < 2; r++) begin
            drive("t4_rresp", IDLE_BLK, 3'b100, {2'b01, PS, 8'h1c});
            drive("t4_rreq",  IDLE_BLK, 3'b001, {2'b01, PR, 8'h1a});
            drive("t4_wreq",  IDLE_BLK, 3'b010, {2'b01, PW, 8'h1b});
        end
        for (int c = 0; c < 3; c++) set_msg(c, 1'b0, 1'b0, 56'd0);

        // 5: rresp lock holds while rresp_valid drops; rreq stays blocked.
        set_msg(2, 1'b1, 1'b0, P51);
        set_msg(0, 1'b1, 1'b1, PR);
        drive("t5_first", IDLE_BLK, 3'b100, {2'b01, P51, 8'h2b});
        check_busy("t5_busy", 1'b1);
        set_msg(2, 1'b0, 1'b0, 56'd0);
        drive("t5_gap0", IDLE_BLK, 3'b000, IDLE_BLK);
        drive("t5_gap1", IDLE_BLK, 3'b000, IDLE_BLK);
        check_busy("t5_busy_gap", 1'b1);
        set_msg(2, 1'b1, 1'b1, P52);
        drive("t5_last", IDLE_BLK, 3'b100, {2'b01, P52, 8'h0b});
        set_msg(2, 1'b0, 1'b0, 56'd0);
        check_busy("t5_busy_done", 1'b0);
        drive("t5_rreq", IDLE_BLK, 3'b001, {2'b01, PR, 8'h1a});
        set_msg(0, 1'b0, 1'b0, 56'd0);

        // 6: reset mid-message; the restarted message begins as FIRST.
        set_msg(2, 1'b1, 1'b0, P61);
        drive("t6_first", IDLE_BLK, 3'b100, {2'b01, P61, 8'h2b});
        check_busy("t6_busy", 1'b1);
        set_msg(2, 1'b0, 1'b0, 56'd0);
        bus.encoded_tx_hdr  = DATA_BLK[65:64];
        bus.encoded_tx_data = DATA_BLK[63:0];
        #1 rst = 1'b1;
        #1;
        check("t6_rst_out", {bus.out_encoded_tx_hdr, bus.out_encoded_tx_data}, IDLE_BLK);
        check_busy("t6_rst_busy", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set_msg(2, 1'b1, 1'b0, P61);
        drive("t6_restart", IDLE_BLK, 3'b100, {2'b01, P61, 8'h2b});
        check_busy("t6_busy2", 1'b1);
        set_msg(2, 1'b1, 1'b1, P62);
        drive("t6_last", IDLE_BLK, 3'b100, {2'b01, P62, 8'h0b});
        set_msg(2, 1'b0, 1'b0, 56'd0);
        check_busy("t6_busy_done", 1'b0);
        drive("t6_tail", IDLE_BLK, 3'b000, IDLE_BLK);

        @(negedge clk);
        check("queue_drained", 66'(exp_q.size()), 66'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
